// File: rtl/mac_array_ctrl_if.sv
// Handshake/instruction bundle between the core (master) and mac_array_ctrl (slave).
// MAC_ARRAY_CTRL_PERF_EN adds the cyc_cnt busy-cycle counter to the bundle.
interface mac_array_ctrl_if #(
  parameter int row        = 8,
  parameter int inst_width = 4,
  parameter int len_bw     = 8
);
  logic                      start;
  logic                      mode;
  logic [len_bw-1:0]         len;
  logic                      abort;
  logic [row*inst_width-1:0] inst_row;
  logic                      x_rd;
  logic                      w_rd;
  logic                      busy;
  logic                      done;
`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0]               cyc_cnt;

  modport master (
    output start, mode, len, abort,
    input  inst_row, x_rd, w_rd, busy, done, cyc_cnt
  );
  modport slave (
    input  start, mode, len, abort,
    output inst_row, x_rd, w_rd, busy, done, cyc_cnt
  );
`else
  modport master (
    output start, mode, len, abort,
    input  inst_row, x_rd, w_rd, busy, done
  );
  modport slave (
    input  start, mode, len, abort,
    output inst_row, x_rd, w_rd, busy, done
  );
`endif
endinterface

// File: rtl/mac_array_ctrl.sv
// Systolic-array sequencer: WS = kernel load/exec/drain, OS = exec/drain/flush, with a
// per-row skewed instruction chain. MAC_ARRAY_CTRL_PERF_EN adds a saturating busy-cycle counter.
module mac_array_ctrl #(
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int inst_width = 4,
  parameter int len_bw     = 8
) (
  input  logic               clk,
  input  logic               reset,
  mac_array_ctrl_if.slave    bus
);

  localparam int DRAIN_LEN = row + col;
  localparam int DRAIN_BW  = $clog2(DRAIN_LEN) + 1;
  localparam int CNT_W     = (len_bw > DRAIN_BW) ? len_bw : DRAIN_BW;

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [inst_width-1:0] inst_t;
  typedef logic [len_bw-1:0]     len_t;

  localparam inst_t INST_NOP      = inst_t'(0);
  localparam inst_t INST_WS_KLD   = inst_t'(4'b0001);
  localparam inst_t INST_WS_EXEC  = inst_t'(4'b0010);
  localparam inst_t INST_OS_EXEC  = inst_t'(4'b0100);
  localparam inst_t INST_OS_FLUSH = inst_t'(4'b1000);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KLOAD,
    S_EXEC,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   mode_q, mode_d;
  len_t   len_q, len_d;
  inst_t  skew_q [1:row-1];
  inst_t  skew_d [1:row-1];

  logic   accept;
  logic   abort_job;
  logic   phase_done;
  inst_t  inst0;

  // Counter value loaded on entry to a phase: phase length minus one.
  function automatic cnt_t entry_count(input state_e s, input len_t l);
    cnt_t c;
    c = '0;
    case (s)
      S_KLOAD: c = cnt_t'(row - 1);
      S_EXEC:  c = cnt_t'(l) - cnt_t'(1);
      S_DRAIN: c = cnt_t'(DRAIN_LEN - 1);
      S_FLUSH: c = cnt_t'(row - 1);
      default: c = '0;
    endcase
    return c;
  endfunction

  // NOTE: every signal gets a default at the top of an always_comb so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    len_d      = len_q;
    accept     = 1'b0;
    abort_job  = (state_q != S_IDLE) && bus.abort;
    phase_done = (cnt_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          accept = 1'b1;
          if (!bus.mode)             state_d = S_KLOAD;
          else if (bus.len != '0)    state_d = S_EXEC;
          else                       state_d = S_DRAIN;
        end
      end
      S_KLOAD: if (phase_done) state_d = (len_q != '0) ? S_EXEC : S_DRAIN;
      S_EXEC:  if (phase_done) state_d = S_DRAIN;
      S_DRAIN: if (phase_done) state_d = mode_q ? S_FLUSH : S_DONE;
      S_FLUSH: if (phase_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      mode_d = bus.mode;
      len_d  = bus.len;
    end
    if (abort_job) state_d = S_IDLE;

    // No phase transitions to itself, so a state change marks a fresh phase entry.
    if (state_d != state_q)      cnt_d = entry_count(state_d, len_d);
    else if (state_q != S_IDLE)  cnt_d = cnt_q - cnt_t'(1);
  end

  always_comb begin
    inst0 = INST_NOP;
    case (state_q)
      S_KLOAD: inst0 = INST_WS_KLD;
      S_EXEC:  inst0 = mode_q ? INST_OS_EXEC : INST_WS_EXEC;
      S_FLUSH: inst0 = INST_OS_FLUSH;
      default: inst0 = INST_NOP;
    endcase
  end

  // Diagonal wavefront: lane r sees lane 0 delayed r cycles; an abort wipes the whole chain.
  always_comb begin
    for (int r = 1; r < row; r++) skew_d[r] = INST_NOP;
    if (!abort_job) begin
      skew_d[1] = inst0;
      for (int r = 2; r < row; r++) skew_d[r] = skew_q[r-1];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      len_q   <= '0;
      // NOTE: the skew array is a shift register of flops, not a RAM, so it is reset
      // explicitly; lanes must read 0000 right after reset.
      for (int r = 1; r < row; r++) skew_q[r] <= INST_NOP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      for (int r = 1; r < row; r++) skew_q[r] <= skew_d[r];
    end
  end

  always_comb begin
    bus.inst_row = '0;
    bus.inst_row[inst_width-1:0] = inst0;
    for (int r = 1; r < row; r++) bus.inst_row[r*inst_width +: inst_width] = skew_q[r];
  end

  assign bus.x_rd = (state_q == S_EXEC);
  assign bus.w_rd = (state_q == S_KLOAD);
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);

`ifdef MAC_ARRAY_CTRL_PERF_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (accept)                                   cyc_cnt_d = '0;
    else if (bus.busy && (cyc_cnt_q != '1))       cyc_cnt_d = cyc_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) cyc_cnt_q <= '0;
    else       cyc_cnt_q <= cyc_cnt_d;
  end

  assign bus.cyc_cnt = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: job-level queue model checked every cycle, plus
// literal expectations for the directed jobs. Checks cyc_cnt when MAC_ARRAY_CTRL_PERF_EN is set.
module tb_mac_array_ctrl;
  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int IW  = 4;
  localparam int LBW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_array_ctrl_if #(.row(ROW), .inst_width(IW), .len_bw(LBW)) bus ();

  mac_array_ctrl #(.row(ROW), .col(COL), .inst_width(IW), .len_bw(LBW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model: one planned entry per remaining job cycle ----------------
  typedef struct packed {
    logic [3:0] inst;
    logic       xr;
    logic       wr;
    logic       dn;
  } step_t;

  step_t       plan[$];
  logic [3:0]  hist [ROW];
  bit          model_ok = 1'b0;
  int          cyc = 0;
  logic [31:0] perf = '0;

  task automatic push(input int n, input logic [3:0] i, input bit xr, input bit wr, input bit dn);
    step_t s;
    s.inst = i; s.xr = xr; s.wr = wr; s.dn = dn;
    for (int k = 0; k < n; k++) plan.push_back(s);
  endtask

  task automatic build_job(input bit m, input int l);
    if (!m) begin
      push(ROW, 4'b0001, 1'b0, 1'b1, 1'b0);
      push(l, 4'b0010, 1'b1, 1'b0, 1'b0);
      push(ROW + COL, 4'b0000, 1'b0, 1'b0, 1'b0);
    end else begin
      push(l, 4'b0100, 1'b1, 1'b0, 1'b0);
      push(ROW + COL, 4'b0000, 1'b0, 1'b0, 1'b0);
      push(ROW, 4'b1000, 1'b0, 1'b0, 1'b0);
    end
    push(1, 4'b0000, 1'b0, 1'b0, 1'b1);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      plan.delete();
      for (int r = 0; r < ROW; r++) hist[r] = 4'b0;
      perf = '0;
      model_ok = 1'b1;
    end else begin
      bit cleared;
      cleared = 1'b0;
      if (plan.size() != 0) begin
        if (perf != 32'hffff_ffff) perf = perf + 1;
        if (bus.abort) begin
          plan.delete();
          cleared = 1'b1;
        end else begin
          void'(plan.pop_front());
        end
      end else if (bus.start && !bus.abort) begin
        build_job(bus.mode, int'(bus.len));
        perf = '0;
      end
      if (cleared) begin
        for (int r = 0; r < ROW; r++) hist[r] = 4'b0;
      end else begin
        for (int r = ROW - 1; r > 0; r--) hist[r] = hist[r-1];
        hist[0] = (plan.size() != 0) ? plan[0].inst : 4'b0;
      end
    end
  end

  // ---------------- compare process + directed-job counters ----------------
  int busy_n, xrd_n, wrd_n, done_n, done_at, start_cyc;
  logic [ROW*IW-1:0] exp_row;

  task automatic clr_counts();
    busy_n = 0; xrd_n = 0; wrd_n = 0; done_n = 0; done_at = -1;
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      for (int r = 0; r < ROW; r++) exp_row[r*IW +: IW] = hist[r];
      check("inst_row", bus.inst_row, exp_row);
      check("busy", bus.busy, plan.size() != 0);
      check("done", bus.done, (plan.size() != 0) && plan[0].dn);
      check("x_rd", bus.x_rd, (plan.size() != 0) && plan[0].xr);
      check("w_rd", bus.w_rd, (plan.size() != 0) && plan[0].wr);
`ifdef MAC_ARRAY_CTRL_PERF_EN
      check("cyc_cnt", bus.cyc_cnt, perf);
`endif
      if (bus.busy === 1'b1) busy_n++;
      if (bus.x_rd === 1'b1) xrd_n++;
      if (bus.w_rd === 1'b1) wrd_n++;
      if (bus.done === 1'b1) begin done_n++; done_at = cyc; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && done_n == 0; i++) tick();
    if (done_n == 0) check("job_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_job(input bit m, input int l, input int max_cyc);
    clr_counts();
    bus.start = 1'b1; bus.mode = m; bus.len = LBW'(l);
    start_cyc = cyc;
    tick();
    bus.start = 1'b0; bus.mode = 1'($urandom); bus.len = LBW'($urandom);
    wait_done(max_cyc);
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.mode = 1'b0; bus.len = '0; bus.abort = 1'b0;
    clr_counts();
    repeat (3) tick();
    @(negedge clk);
    check("rst_inst_row", bus.inst_row, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_strobes", {bus.x_rd, bus.w_rd}, 2'b00);
`ifdef MAC_ARRAY_CTRL_PERF_EN
    check("rst_cyc_cnt", bus.cyc_cnt, 32'd0);
`endif
    reset = 1'b0;
    tick();

    // WS, len 3: 4 kload + 3 exec + 8 drain + done
    run_job(1'b0, 3, 60);
    check("ws_done_latency", done_at - start_cyc, 16);
    check("ws_busy_cycles", busy_n, 16);
    check("ws_w_rd_cycles", wrd_n, 4);
    check("ws_x_rd_cycles", xrd_n, 3);
    check("ws_done_pulses", done_n, 1);
`ifdef MAC_ARRAY_CTRL_PERF_EN
    check("ws_cyc_cnt", bus.cyc_cnt, 32'd16);
`endif

    // OS, len 5: 5 exec + 8 drain + 4 flush + done
    run_job(1'b1, 5, 60);
    check("os_done_pulses", done_n, 1);
    check("os_x_rd_cycles", xrd_n, 5);
    check("os_w_rd_cycles", wrd_n, 0);
    check("os_busy_cycles", busy_n, 18);

    // len 0 in both modes
    run_job(1'b0, 0, 60);
    check("ws0_done_latency", done_at - start_cyc, 13);
    check("ws0_x_rd_cycles", xrd_n, 0);
    run_job(1'b1, 0, 60);
    check("os0_done_latency", done_at - start_cyc, 13);
    check("os0_x_rd_cycles", xrd_n, 0);

    // Maximum length runs the full count
    run_job(1'b1, 255, 400);
    check("max_x_rd_cycles", xrd_n, 255);
    check("max_busy_cycles", busy_n, 268);

    // Abort on the 2nd EXEC cycle of a WS job, then restart two cycles later
    clr_counts();
    bus.start = 1'b1; bus.mode = 1'b0; bus.len = 8'd6;
    tick();
    bus.start = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("abort_pre_lane0", bus.inst_row[3:0], 4'b0010);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    @(negedge clk);
    check("abort_inst_row", bus.inst_row, '0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_no_done", done_n, 0);
    tick();
    bus.start = 1'b1; bus.mode = 1'b0; bus.len = 8'd2;
    tick();
    bus.start = 1'b0;
    @(negedge clk);
    check("restart_busy", bus.busy, 1'b1);
    wait_done(60);
    tick();

    // Abort together with start in IDLE: start is dropped
    bus.start = 1'b1; bus.abort = 1'b1; bus.mode = 1'b1; bus.len = 8'd3;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    @(negedge clk);
    check("abort_wins_busy", bus.busy, 1'b0);
    tick();

    // start held high through several jobs, mode/len wiggling
    clr_counts();
    bus.start = 1'b1; bus.mode = 1'b0; bus.len = 8'd2;
    for (int i = 0; i < 45; i++) begin
      tick();
      bus.mode = 1'($urandom);
      bus.len  = LBW'($urandom_range(0, 4));
    end
    bus.start = 1'b0;
    check("held_start_jobs", done_n >= 2, 1'b1);
    for (int i = 0; i < 100 && bus.busy === 1'b1; i++) tick();
    tick();

    // Reset in the 2nd FLUSH cycle of an OS len-2 job
    bus.start = 1'b1; bus.mode = 1'b1; bus.len = 8'd2;
    tick();
    bus.start = 1'b0;
    repeat (11) tick();
    @(negedge clk);
    check("flush_lane0", bus.inst_row[3:0], 4'b1000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_inst_row", bus.inst_row, '0);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_done", bus.done, 1'b0);
`ifdef MAC_ARRAY_CTRL_PERF_EN
    check("rst_mid_cyc_cnt", bus.cyc_cnt, 32'd0);
`endif
    tick();

    // Randomised traffic: sporadic starts, aborts and rare resets
    for (int i = 0; i < 2000; i++) begin
      bus.start = ($urandom_range(0, 3) == 0);
      bus.mode  = 1'($urandom);
      bus.len   = ($urandom_range(0, 9) == 0) ? LBW'($urandom_range(0, 40)) : LBW'($urandom_range(0, 6));
      bus.abort = ($urandom_range(0, 59) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      tick();
    end
    bus.start = 1'b0; bus.abort = 1'b0; reset = 1'b0;
    for (int i = 0; i < 200 && bus.busy === 1'b1; i++) tick();
    check("final_idle", bus.busy, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
